// File: rtl/queue_pkg.sv
// Shared constants, pointer type and wrap helper for the circular-buffer queue.
// Consumers: queue_fifo (optional error flags via QUEUE_ERR_FLAGS_EN).
package queue_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_DEPTH  = 8;

   // Wide enough for the largest legal depth (256 entries -> indices 0..255)
   typedef logic [7:0] ptr_t;

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_DEQ  = 2'b01,
      OP_ENQ  = 2'b10,
      OP_BOTH = 2'b11
   } op_e;

   function automatic ptr_t next_ptr(input ptr_t ptr, input int unsigned depth);
      return (ptr == ptr_t'(depth - 1)) ? '0 : ptr + ptr_t'(1);
   endfunction

endpackage

// File: rtl/queue_fifo_rise_detect.sv
// Registered rising-edge detector: one-cycle pulse on each 0->1 transition of level.
module rise_detect (
   input  logic clock_10KHZ,
   input  logic reset,
   input  logic level,
   output logic rise
);

   logic prev;

   always_ff @(posedge clock_10KHZ or negedge reset) begin
      if (!reset) prev <= 1'b0;
      else        prev <= level;
   end

   assign rise = level & ~prev;

endmodule

// File: rtl/queue_fifo.sv
// Circular-buffer FIFO with edge-triggered enqueue/dequeue, flush and status.
// Define QUEUE_ERR_FLAGS_EN to add sticky overflow_out/underflow_out flags.
module queue_fifo
   import queue_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned LEN_W  = $clog2(DEPTH + 1)
) (
   input  logic              clock_10KHZ,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              enqueue_in,
   input  logic              dequeue_in,
   input  logic              flush_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid_out,
   output logic [LEN_W-1:0]  len_out,
   output logic              full_out,
   output logic              empty_out
`ifdef QUEUE_ERR_FLAGS_EN
   ,
   output logic              overflow_out,
   output logic              underflow_out
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [LEN_W-1:0]  len;
   logic              enq_evt, deq_evt;
   logic              do_enq, do_deq, ovf_evt, udf_evt;
   op_e               op;

   rise_detect u_enq_edge (
      .clock_10KHZ (clock_10KHZ),
      .reset       (reset),
      .level       (enqueue_in),
      .rise        (enq_evt)
   );

   rise_detect u_deq_edge (
      .clock_10KHZ (clock_10KHZ),
      .reset       (reset),
      .level       (dequeue_in),
      .rise        (deq_evt)
   );

   assign full_out  = (len == LEN_W'(DEPTH));
   assign empty_out = (len == '0);
   assign len_out   = len;

   always_comb begin
      do_enq  = 1'b0;
      do_deq  = 1'b0;
      ovf_evt = 1'b0;
      udf_evt = 1'b0;
      op      = op_e'({enq_evt, deq_evt});
      if (!flush_in) begin
         unique case (op)
            OP_ENQ: begin
               do_enq  = ~full_out;
               ovf_evt = full_out;
            end
            OP_DEQ: begin
               do_deq  = ~empty_out;
               udf_evt = empty_out;
            end
            // Simultaneous requests on an empty queue: enqueue wins, dequeue underflows
            OP_BOTH: begin
               do_enq  = 1'b1;
               do_deq  = ~empty_out;
               udf_evt = empty_out;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock_10KHZ) begin
      if (do_enq) mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clock_10KHZ or negedge reset) begin
      if (!reset) begin
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         len            <= '0;
         data_out       <= '0;
         data_valid_out <= 1'b0;
      end else if (flush_in) begin
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         len            <= '0;
         data_valid_out <= 1'b0;
      end else begin
         data_valid_out <= do_deq;
         if (do_enq) wr_ptr <= PTR_W'(next_ptr(ptr_t'(wr_ptr), DEPTH));
         if (do_deq) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= PTR_W'(next_ptr(ptr_t'(rd_ptr), DEPTH));
         end
         if (do_enq && !do_deq)      len <= len + LEN_W'(1);
         else if (do_deq && !do_enq) len <= len - LEN_W'(1);
      end
   end

`ifdef QUEUE_ERR_FLAGS_EN
   always_ff @(posedge clock_10KHZ or negedge reset) begin
      if (!reset) begin
         overflow_out  <= 1'b0;
         underflow_out <= 1'b0;
      end else if (flush_in) begin
         overflow_out  <= 1'b0;
         underflow_out <= 1'b0;
      end else begin
         if (ovf_evt) overflow_out  <= 1'b1;
         if (udf_evt) underflow_out <= 1'b1;
      end
   end
`else
   logic unused_err;
   assign unused_err = ovf_evt ^ udf_evt;
`endif

endmodule
